regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16x16-bit register heap between two requesters: the pipeline writeback stage (WB) and the trap/interrupt unit (TR), which writes SP/T/IH/RS(EPC).
- Grants one write per cycle, registers the winning write toward the heap, and reports the in-flight write so hazard logic can bypass or stall.
- Fixed WB priority, with a starvation limit that guarantees TR progress.

Parameters:
- REG_WIDTH, 4, register address width.
- NUM, 16, number of registers; width of pend_mask_o.
- STARVE_MAX, 4, consecutive TR-blocked cycles before TR is forced to win one grant (range 1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- wb_valid_i  in  1  WB write request.
- wb_addr_i  in  REG_WIDTH  WB destination register.
- wb_data_i  in  16  WB write data.
- wb_ready_o  out  1  WB request accepted this cycle.
- tr_valid_i  in  1  TR write request.
- tr_addr_i  in  REG_WIDTH  TR destination register.
- tr_data_i  in  16  TR write data.
- tr_ready_o  out  1  TR request accepted this cycle.
- regwrite_o  out  1  heap write enable, ACTIVE-LOW (0 = write), registered.
- wrreg_o  out  REG_WIDTH  heap write address, registered.
- wdata_o  out  16  heap write data, registered.
- rdreg1_i, rdreg2_i  in  REG_WIDTH  read addresses also presented to the heap.
- byp_hit1_o, byp_hit2_o  out  1  read address matches the in-flight write.
- byp_data_o  out  16  in-flight write data (equals wdata_o).
- pend_mask_o  out  NUM  one-hot of the in-flight write address, or all zero.
- starve_o  out  1  high while in state TR_PRI.

Behaviour:
- Handshake: a transfer occurs when valid and ready are both high in the same cycle. Ready outputs are combinational from valids and state. At most one ready is high per cycle. Ready is never high without its valid. Both readys are 0 while RST is high.
- FSM states: WB_PRI (reset state) and TR_PRI.
- In WB_PRI:
  - wb_valid_i grants WB.
  - Otherwise tr_valid_i grants TR.
  - Starvation counter scnt (4 bits) increments when tr_valid_i=1 and WB wins. It clears when TR wins or when tr_valid_i=0.
  - When scnt reaches STARVE_MAX-1 and is incrementing, the FSM enters TR_PRI on the next cycle and scnt clears.
- In TR_PRI:
  - tr_valid_i grants TR; the FSM then returns to WB_PRI.
  - If tr_valid_i=0 (TR withdrew), WB may be granted; the FSM returns to WB_PRI.
  - The FSM stays in TR_PRI no longer than one cycle.
- Output register, 1-cycle latency:
  - On a grant at edge N, after edge N: regwrite_o=0, wrreg_o/wdata_o hold the granted address/data.
  - With no grant: regwrite_o=1; wrreg_o/wdata_o hold their last values.
  - The heap samples on the falling edge, so outputs are stable half a cycle before use.
- Bypass:
  - byp_hitk_o = (regwrite_o==0) && (rdregk_i==wrreg_o), combinational.
  - byp_data_o = wdata_o.
  - pend_mask_o bit wrreg_o is set only while regwrite_o=0.
  - Register addresses >= NUM are passed through unchanged, but never set pend_mask_o.
- Same-address back-to-back writes commit in grant order; the later write wins. No merging.
- Reset values: regwrite_o=1, wrreg_o=0, wdata_o=0, byp_hit*=0, pend_mask_o=0, starve_o=0, state=WB_PRI, scnt=0.
- Reset mid-operation: an in-flight registered write is discarded (regwrite_o=1 after the reset edge). Requests present during reset are not accepted.
- Requesters must hold valid/addr/data stable until accepted; the arbiter does not latch unaccepted requests.

Test Plan:
- Reset: drive both valids high with RST=1 for 2 cycles -> readys 0, regwrite_o=1, pend_mask_o=0. After release, WB is granted first.
- Single write: WB addr=3, data=0xBEEF for 1 cycle -> wb_ready_o=1 that cycle. Next cycle regwrite_o=0, wrreg_o=3, wdata_o=0xBEEF, pend_mask_o=0x0008. Following cycle regwrite_o=1.
- Starvation (STARVE_MAX=4): WB valid continuously, TR valid from cycle 0 with addr=0xB, data=0x1234 -> WB granted cycles 0-3, starve_o=1 at cycle 4, tr_ready_o=1 at cycle 4, wrreg_o=0xB at cycle 5. WB is granted again at cycle 5.
- Bypass: in-flight write addr=5, data=0x00A5; rdreg1_i=5, rdreg2_i=6 -> byp_hit1_o=1, byp_hit2_o=0, byp_data_o=0x00A5. With no write in flight, both hits are 0.
- Back-to-back same address: WB addr=2 writes 0x1111 then 0x2222 on consecutive cycles -> two consecutive regwrite_o=0 cycles, wdata_o 0x1111 then 0x2222. The heap reads 0x2222 afterwards.
- Reset mid-write: assert RST in the cycle after a grant -> regwrite_o=1 after the reset edge, and the heap register is unchanged on the following falling edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter for the 16x16 register heap: WB has fixed
// priority, TR is forced through after STARVE_MAX consecutive blocked cycles.
module regfile_write_arbiter #(
   parameter int REG_WIDTH  = 4,
   parameter int NUM        = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 wb_valid_i,
   input  logic [REG_WIDTH-1:0] wb_addr_i,
   input  logic [15:0]          wb_data_i,
   output logic                 wb_ready_o,
   input  logic                 tr_valid_i,
   input  logic [REG_WIDTH-1:0] tr_addr_i,
   input  logic [15:0]          tr_data_i,
   output logic                 tr_ready_o,
   output logic                 regwrite_o,
   output logic [REG_WIDTH-1:0] wrreg_o,
   output logic [15:0]          wdata_o,
   input  logic [REG_WIDTH-1:0] rdreg1_i,
   input  logic [REG_WIDTH-1:0] rdreg2_i,
   output logic                 byp_hit1_o,
   output logic                 byp_hit2_o,
   output logic [15:0]          byp_data_o,
   output logic [NUM-1:0]       pend_mask_o,
   output logic                 starve_o
);

   localparam int DATA_W = 16;

   typedef enum logic {WB_PRI, TR_PRI} state_t;

   state_t                 state, state_nxt;
   logic [3:0]             scnt, scnt_nxt;
   logic                   wb_gnt_p0, tr_gnt_p0;
   logic                   vld_p1;
   logic [REG_WIDTH-1:0]   addr_p1;
   logic [DATA_W-1:0]      data_p1;

   // Stage p0: grant decision and starvation tracking
   always_comb begin
      state_nxt = WB_PRI;
      scnt_nxt  = '0;
      wb_gnt_p0 = 1'b0;
      tr_gnt_p0 = 1'b0;
      if (!RST) begin
         case (state)
            WB_PRI: begin
               wb_gnt_p0 = wb_valid_i;
               tr_gnt_p0 = !wb_valid_i && tr_valid_i;
               // scnt only survives while TR keeps losing to WB
               if (tr_valid_i && wb_gnt_p0) begin
                  if (scnt == 4'(STARVE_MAX - 1))
                     state_nxt = TR_PRI;
                  else
                     scnt_nxt = scnt + 4'd1;
               end
            end
            TR_PRI: begin
               tr_gnt_p0 = tr_valid_i;
               wb_gnt_p0 = !tr_valid_i && wb_valid_i;
            end
            default: ;
         endcase
      end
   end

   // Stage p1: registered write toward the heap
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= WB_PRI;
         scnt    <= '0;
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         data_p1 <= '0;
      end else begin
         state  <= state_nxt;
         scnt   <= scnt_nxt;
         vld_p1 <= wb_gnt_p0 || tr_gnt_p0;
         if (wb_gnt_p0) begin
            addr_p1 <= wb_addr_i;
            data_p1 <= wb_data_i;
         end else if (tr_gnt_p0) begin
            addr_p1 <= tr_addr_i;
            data_p1 <= tr_data_i;
         end
      end
   end

   assign wb_ready_o = wb_gnt_p0;
   assign tr_ready_o = tr_gnt_p0;
   assign starve_o   = (state == TR_PRI);
   assign regwrite_o = !vld_p1;
   assign wrreg_o    = addr_p1;
   assign wdata_o    = data_p1;
   assign byp_data_o = data_p1;
   assign byp_hit1_o = vld_p1 && (rdreg1_i == addr_p1);
   assign byp_hit2_o = vld_p1 && (rdreg2_i == addr_p1);

   // Out-of-range addresses simply match no bit of the mask
   always_comb begin
      pend_mask_o = '0;
      for (int i = 0; i < NUM; i++)
         pend_mask_o[i] = vld_p1 && (32'(addr_p1) == i);
   end

endmodule
